fp_share_arbiter: RTL and testbench
===================================

Name: fp_share_arbiter

Overview:
- Round-robin scheduler that shares one floating-point unit (FP) among N requesters.
- Per job, sequences the following:
  - accepts one requester's operands;
  - drives the shared input mux and the input-register load;
  - pulses the FP start;
  - waits for doneFP, guarded by a watchdog;
  - loads the output register;
  - runs the result handshake back to the owning requester only.
- Sits between the requester-side input/output wrappers and the FP datapath.

Parameters:
- N, 4, number of requesters.
- SELW, 2, width of the owner index; must equal ceil(log2(N)).
- TIMEOUT, 64, maximum cycles spent in WAIT before the job is aborted.
- TW, 7, watchdog counter width; must satisfy 2^TW > TIMEOUT.

Ports:
- clk  in  1  rising-edge clock, sole clock of the block.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- inputReady  in  N  request from requester i; operands valid while high.
- inputAccept  out  N  one-hot, one-cycle pulse: operands of the owner consumed.
- selIn  out  SELW  owner index; drives the operand mux and result routing.
- ldIn  out  1  load the shared FP input register.
- startFP  out  1  one-cycle FP start pulse.
- doneFP  in  1  FP completion pulse; sampled only in WAIT.
- ldOut  out  1  load the shared result register.
- resultReady  out  N  one-hot; result of the owner is valid.
- resultAccept  in  N  requester i has taken its result.
- resultErr  out  1  qualifies resultReady: 1 means the job timed out and the result is invalid.
- busy  out  1  high in every state except IDLE.

Behaviour:
- State register: IDLE, GRANT, START, WAIT, LDOUT, READY.
- Outputs are Moore: decoded from the state and the registered owner/err only.
- Reset (rst=0, takes effect immediately, async):
  - state=IDLE; owner=0; last=N-1; err=0; watchdog=0.
  - All outputs 0 (selIn=0).
- IDLE:
  - If any inputReady bit is set, pick the first set bit searching from (last+1) mod N upward, wrapping.
  - Register it as owner and go to GRANT; otherwise stay in IDLE.
  - After reset, requester 0 has highest priority.
- GRANT:
  - ldIn=1 and inputAccept[owner]=1 for exactly one cycle.
  - Go to START unconditionally.
  - The owner is latched; inputReady changes during GRANT are ignored.
- START:
  - startFP=1 for one cycle; watchdog cleared to 0.
  - Go to WAIT.
- WAIT: the watchdog increments every cycle.
  - doneFP=1 → LDOUT.
  - Otherwise, watchdog==TIMEOUT-1 → set err=1 and go to READY, skipping LDOUT.
  - If doneFP arrives in the same cycle as the timeout, doneFP wins: err stays 0 and the next state is LDOUT.
- LDOUT:
  - ldOut=1 for one cycle, err=0.
  - Go to READY.
- READY:
  - resultReady[owner]=1 and resultErr=err, both held until resultAccept[owner]=1.
  - On resultAccept[owner]: last=owner, err cleared, go to IDLE.
  - resultAccept bits of non-owners are ignored.
- Pulses in the wrong state:
  - doneFP outside WAIT is ignored (no latching).
  - resultAccept outside READY is ignored.
- Latency:
  - inputReady seen in IDLE at cycle 0 gives inputAccept/ldIn at cycle 1, startFP at 2, WAIT from 3.
  - doneFP at cycle k gives ldOut at k+1 and resultReady at k+2.
- Throughput:
  - Minimum job is 6 cycles (doneFP in the first WAIT cycle, accept in the first READY cycle).
  - No new grant is issued before the returning IDLE cycle.
- Fairness: a requester holding inputReady continuously is granted within N jobs.
- Reset mid-operation:
  - Aborts the job with no further pulses.
  - A pending resultReady drops asynchronously.
  - The round-robin history is lost.
- Illegal or unused state encodings recover to IDLE on the next clock.

Decomposition:
- Shared package/include:
  - state encoding constants (IDLE=0 … READY=5, 3-bit);
  - the default N/SELW/TIMEOUT values.
- One sub-module, rr_pick:
  - purely combinational;
  - inputs: req[N], last[SELW]; outputs: any, idx[SELW];
  - reusable by other arbiters.

Test Plan:
- Single request:
  - Stimulus: reset release; inputReady=0001; doneFP 3 cycles after startFP; resultAccept[0] 2 cycles after resultReady.
  - Required: inputAccept=0001 at cycle 1, startFP at 2, ldOut one cycle after doneFP, resultReady=0001 with resultErr=0, busy falls after the accept.
- Round robin:
  - Stimulus: inputReady=1111 held for 5 jobs.
  - Required: grant order 0,1,2,3,0; selIn matches the owner during each job.
- Timeout:
  - Stimulus: inputReady=0100, doneFP never asserted.
  - Required: exactly TIMEOUT=64 WAIT cycles, no ldOut, resultReady=0100 with resultErr=1; after the accept, resultErr=0.
- Race and stray pulses:
  - Stimulus: doneFP on the final watchdog cycle; in a separate job, stray doneFP in READY and resultAccept=0010 while owner=0.
  - Required: race goes to LDOUT with resultErr=0; stray doneFP ignored; non-owner accept ignored, resultReady stays 0001.
- Async reset:
  - Stimulus: rst=0 asserted mid-WAIT with no clock edge.
  - Required: all outputs 0 immediately; after release with inputReady=1000, requester 3 is granted.
- Late requester:
  - Stimulus: inputReady=0010 rises during GRANT of requester 0.
  - Required: job 0 completes untouched; requester 1 is granted in the next IDLE cycle.

Source files
------------

// File: rtl/fp_share_arbiter_pkg.sv
// Shared definitions for the FP-unit sharing arbiter: state encoding and default sizing.
package fp_share_arbiter_pkg;

  localparam int unsigned DEF_N       = 4;
  localparam int unsigned DEF_SELW    = 2;
  localparam int unsigned DEF_TIMEOUT = 64;
  localparam int unsigned DEF_TW      = 7;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GRANT = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_LDOUT = 3'd4,
    ST_READY = 3'd5
  } state_t;

endpackage

// File: rtl/fp_share_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request bit searching upward from last+1, wrapping.
module rr_pick
  import fp_share_arbiter_pkg::*;
#(
  parameter int unsigned N    = DEF_N,
  parameter int unsigned SELW = DEF_SELW
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] last,
  output logic            any,
  output logic [SELW-1:0] idx
);

  logic [SELW-1:0] pos;
  logic            found;

  always_comb begin
    idx   = '0;
    pos   = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= N; k++) begin
      pos = SELW'((32'(last) + k) % N);
      if (!found && req[pos]) begin
        idx   = pos;
        found = 1'b1;
      end
    end
    any = found;
  end

endmodule

// File: rtl/fp_share_arbiter.sv
// Round-robin scheduler sharing one FP unit among N requesters, with a WAIT watchdog.
module fp_share_arbiter
  import fp_share_arbiter_pkg::*;
#(
  parameter int unsigned N       = DEF_N,
  parameter int unsigned SELW    = DEF_SELW,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT,
  parameter int unsigned TW      = DEF_TW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    inputReady,
  output logic [N-1:0]    inputAccept,
  output logic [SELW-1:0] selIn,
  output logic            ldIn,
  output logic            startFP,
  input  logic            doneFP,
  output logic            ldOut,
  output logic [N-1:0]    resultReady,
  input  logic [N-1:0]    resultAccept,
  output logic            resultErr,
  output logic            busy
);

  state_t          state, state_n;
  logic [SELW-1:0] owner, owner_n;
  logic [SELW-1:0] last, last_n;
  logic            err, err_n;
  logic [TW-1:0]   wdog, wdog_n;
  logic            pick_any;
  logic [SELW-1:0] pick_idx;
  logic [N-1:0]    owner_oh;

  rr_pick #(.N(N), .SELW(SELW)) u_pick (
    .req  (inputReady),
    .last (last),
    .any  (pick_any),
    .idx  (pick_idx)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      owner <= '0;
      last  <= SELW'(N - 1);
      err   <= 1'b0;
      wdog  <= '0;
    end else begin
      state <= state_n;
      owner <= owner_n;
      last  <= last_n;
      err   <= err_n;
      wdog  <= wdog_n;
    end
  end

  always_comb begin
    state_n = state;
    owner_n = owner;
    last_n  = last;
    err_n   = err;
    wdog_n  = wdog;
    case (state)
      ST_IDLE: begin
        if (pick_any) begin
          owner_n = pick_idx;
          state_n = ST_GRANT;
        end
      end
      ST_GRANT: state_n = ST_START;
      ST_START: begin
        wdog_n  = '0;
        state_n = ST_WAIT;
      end
      ST_WAIT: begin
        wdog_n = wdog + 1'b1;
        // doneFP takes priority over a coincident watchdog expiry
        if (doneFP) begin
          state_n = ST_LDOUT;
        end else if (wdog == TW'(TIMEOUT - 1)) begin
          err_n   = 1'b1;
          state_n = ST_READY;
        end
      end
      ST_LDOUT: begin
        err_n   = 1'b0;
        state_n = ST_READY;
      end
      ST_READY: begin
        if (resultAccept[owner]) begin
          last_n  = owner;
          err_n   = 1'b0;
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    owner_oh    = {{(N-1){1'b0}}, 1'b1} << owner;
    inputAccept = (state == ST_GRANT) ? owner_oh : '0;
    ldIn        = (state == ST_GRANT);
    startFP     = (state == ST_START);
    ldOut       = (state == ST_LDOUT);
    resultReady = (state == ST_READY) ? owner_oh : '0;
    resultErr   = (state == ST_READY) && err;
    busy        = (state != ST_IDLE);
    selIn       = owner;
  end

endmodule

// File: tb/tb_fp_share_arbiter.sv
// Randomized self-checking bench for fp_share_arbiter using a job-level timeline model.
module tb_fp_share_arbiter;

  localparam int N       = 4;
  localparam int SELW    = 2;
  localparam int TIMEOUT = 64;
  localparam int TW      = 7;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [N-1:0]    inputReady = '0;
  logic [N-1:0]    inputAccept;
  logic [SELW-1:0] selIn;
  logic            ldIn, startFP, ldOut, resultErr, busy;
  logic            doneFP = 1'b0;
  logic [N-1:0]    resultReady;
  logic [N-1:0]    resultAccept = '0;

  int total = 0;
  int bad   = 0;
  int model_last = N - 1;

  fp_share_arbiter #(.N(N), .SELW(SELW), .TIMEOUT(TIMEOUT), .TW(TW)) dut (
    .clk          (clk),
    .rst          (rst),
    .inputReady   (inputReady),
    .inputAccept  (inputAccept),
    .selIn        (selIn),
    .ldIn         (ldIn),
    .startFP      (startFP),
    .doneFP       (doneFP),
    .ldOut        (ldOut),
    .resultReady  (resultReady),
    .resultAccept (resultAccept),
    .resultErr    (resultErr),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int pick(input logic [N-1:0] r, input int l);
    for (int k = 1; k <= N; k++)
      if (r[(l + k) % N]) return (l + k) % N;
    return -1;
  endfunction

  task automatic check_zero(input string tag);
    check({tag, "_acc"},   32'(inputAccept), 0);
    check({tag, "_ldin"},  32'(ldIn), 0);
    check({tag, "_start"}, 32'(startFP), 0);
    check({tag, "_ldout"}, 32'(ldOut), 0);
    check({tag, "_rdy"},   32'(resultReady), 0);
    check({tag, "_err"},   32'(resultErr), 0);
    check({tag, "_busy"},  32'(busy), 0);
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    inputReady = '0;
    doneFP = 1'b0;
    resultAccept = '0;
    #3;
    check_zero("rst");
    check("rst_sel", 32'(selIn), 0);
    rst = 1'b1;
    model_last = N - 1;
    step();
  endtask

  task automatic idle_gap();
    inputReady = '0;
    doneFP = 1'($urandom);
    resultAccept = 4'($urandom);
    step();
    doneFP = 1'b0;
    resultAccept = '0;
    check_zero("idle");
  endtask

  // done_dly: WAIT cycle index carrying doneFP (-1 = never); abort_at: WAIT index to reset in (-1 = none)
  task automatic run_job(input logic [N-1:0] req, input logic [N-1:0] late, input int done_dly,
                         input int acc_dly, input int abort_at, input bit stray);
    int own;
    logic [N-1:0] oh;
    bit done;
    own = pick(req, model_last);
    oh  = 4'b0001 << own;
    inputReady = req;
    step();
    check("grant_acc", 32'(inputAccept), 32'(oh));
    check("grant_ldin", 32'(ldIn), 1);
    check("grant_sel", 32'(selIn), 32'(own));
    check("grant_start", 32'(startFP), 0);
    inputReady = late;
    doneFP = stray;
    step();
    doneFP = 1'b0;
    check("start_pulse", 32'(startFP), 1);
    check("start_acc", 32'(inputAccept), 0);
    check("start_ldin", 32'(ldIn), 0);
    step();
    done = 1'b0;
    for (int w = 0; w < TIMEOUT; w++) begin
      check("wait_busy", 32'(busy), 1);
      check("wait_ldout", 32'(ldOut), 0);
      check("wait_rdy", 32'(resultReady), 0);
      check("wait_start", 32'(startFP), 0);
      check("wait_sel", 32'(selIn), 32'(own));
      if (w == abort_at) begin
        #2 rst = 1'b0;
        #1;
        check_zero("abort");
        check("abort_sel", 32'(selIn), 0);
        #3 rst = 1'b1;
        model_last = N - 1;
        inputReady = '0;
        step();
        check_zero("post_abort");
        return;
      end
      doneFP = (w == done_dly);
      step();
      doneFP = 1'b0;
      if (w == done_dly) begin
        done = 1'b1;
        break;
      end
    end
    if (done) begin
      check("ldout_pulse", 32'(ldOut), 1);
      check("ldout_rdy", 32'(resultReady), 0);
      step();
    end
    for (int a = 0; a <= acc_dly; a++) begin
      check("ready_rdy", 32'(resultReady), 32'(oh));
      check("ready_err", 32'(resultErr), 32'(!done));
      check("ready_busy", 32'(busy), 1);
      check("ready_ldout", 32'(ldOut), 0);
      check("ready_sel", 32'(selIn), 32'(own));
      resultAccept = (4'($urandom) & ~oh) | ((a == acc_dly) ? oh : 4'b0000);
      doneFP = stray & 1'($urandom);
      step();
      resultAccept = '0;
      doneFP = 1'b0;
    end
    check("end_busy", 32'(busy), 0);
    check("end_rdy", 32'(resultReady), 0);
    check("end_err", 32'(resultErr), 0);
    model_last = own;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "bench timed out");
  end

  initial begin
    int r, dd;
    repeat (2) @(posedge clk);
    #1;
    apply_reset();

    // single request
    run_job(4'b0001, 4'b0000, 2, 2, -1, 1'b0);
    // round robin from reset: 0,1,2,3,0
    apply_reset();
    for (int j = 0; j < 5; j++)
      run_job(4'b1111, 4'b1111, $urandom_range(0, 4), $urandom_range(0, 2), -1, 1'b0);
    // timeout, then race on the final watchdog cycle
    run_job(4'b0100, 4'b0000, -1, 1, -1, 1'b0);
    run_job(4'b0110, 4'b0000, TIMEOUT - 1, 0, -1, 1'b0);
    // stray pulses with owner 0
    run_job(4'b0001, 4'b0000, 1, 3, -1, 1'b1);
    // async reset mid-WAIT, then requester 3
    run_job(4'b0010, 4'b0000, -1, 0, 5, 1'b0);
    run_job(4'b1000, 4'b0000, 0, 0, -1, 1'b0);
    // late requester during GRANT of requester 0
    apply_reset();
    run_job(4'b0001, 4'b0010, 2, 0, -1, 1'b0);
    run_job(4'b0010, 4'b0000, 1, 0, -1, 1'b0);

    for (int j = 0; j < 40; j++) begin
      r = $urandom_range(0, 9);
      if (r == 0) dd = -1;
      else if (r == 1) dd = TIMEOUT - 1;
      else dd = $urandom_range(0, 6);
      if ($urandom_range(0, 3) == 0) idle_gap();
      run_job(4'($urandom_range(1, 15)), 4'($urandom), dd, $urandom_range(0, 3),
              ($urandom_range(0, 19) == 0) ? $urandom_range(0, 3) : -1, 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
